if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipeline. It owns the program counter and issues single-outstanding requests to instruction memory. Returned words go into a 2-entry fetch buffer, and the buffer head is presented to the IF/ID register as instruction plus PC+2. The block consumes the decode stage's redirect outputs (jump/branch target, branch taken) and its combined freeze, and supplies the decode stage's instruction and PC+2 inputs.

---
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding IMem request at a time,
// and queues returned words in a 2-entry buffer whose head feeds the IF/ID register.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        Freze,
  input  logic        Jump,
  input  logic [15:0] JumpAddress,
  input  logic        brTaken,
  input  logic [15:0] BranchAddress,
  output logic        IMem_Req,
  output logic [15:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic        IMem_Valid,
  input  logic [15:0] IMem_Data,
  output logic [15:0] Source_Out,
  output logic [15:0] PCPlus2_Out,
  output logic        Valid_Out
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

  logic [15:0] pc_reg, pc_next;
  logic [15:0] tag_reg, tag_next;
  logic [1:0]  state_reg, state_next;
  logic [1:0]  count_reg, count_next;
  logic [15:0] instr_reg   [2];
  logic [15:0] pcplus2_reg [2];

  logic        redirect;
  logic [15:0] target_raw;
  logic [15:0] target;
  logic        fetch_fire;
  logic        push;
  logic        pop;
  logic        wr_idx;
  logic [15:0] tag_plus2;

  // Branch wins over jump; instructions are halfword aligned.
  assign redirect   = brTaken | Jump;
  assign target_raw = brTaken ? BranchAddress : JumpAddress;
  assign target     = target_raw & 16'hFFFE;

  assign IMem_Req   = rest & (state_reg == ST_FETCH) & (count_reg < 2'd2) & ~redirect;
  assign IMem_Addr  = pc_reg;
  assign fetch_fire = IMem_Req & IMem_Ack;

  assign push      = (state_reg == ST_WAIT) & IMem_Valid & ~redirect;
  assign Valid_Out = (count_reg != 2'd0);
  assign pop       = Valid_Out & ~Freze & ~redirect;
  assign tag_plus2 = tag_reg + 16'd2;

  // Slot the new word lands in after this cycle's pop has shifted the head.
  assign wr_idx = (count_reg == 2'd2) | ((count_reg == 2'd1) & ~pop);

  assign Source_Out  = Valid_Out ? instr_reg[0]   : 16'h0000;
  assign PCPlus2_Out = Valid_Out ? pcplus2_reg[0] : 16'h0000;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    tag_next   = tag_reg;
    count_next = count_reg;
    if (redirect) begin
      pc_next    = target;
      count_next = 2'd0;
      case (state_reg)
        ST_WAIT:    state_next = IMem_Valid ? ST_FETCH : ST_DISCARD;
        ST_DISCARD: state_next = IMem_Valid ? ST_FETCH : ST_DISCARD;
        default:    state_next = ST_FETCH;
      endcase
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (fetch_fire) begin
            tag_next   = pc_reg;
            pc_next    = pc_reg + 16'd2;
            state_next = ST_WAIT;
          end
        end
        ST_WAIT:    if (IMem_Valid) state_next = ST_FETCH;
        ST_DISCARD: if (IMem_Valid) state_next = ST_FETCH;
        default:    state_next = ST_FETCH;
      endcase
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      pc_reg    <= RESET_PC_ALIGNED;
      tag_reg   <= 16'h0000;
      state_reg <= ST_FETCH;
      count_reg <= 2'd0;
    end else begin
      pc_reg    <= pc_next;
      tag_reg   <= tag_next;
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Pop shifts the tail forward; a same-cycle push then writes the freed slot.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      instr_reg[0]   <= 16'h0000;
      instr_reg[1]   <= 16'h0000;
      pcplus2_reg[0] <= 16'h0000;
      pcplus2_reg[1] <= 16'h0000;
    end else begin
      if (pop) begin
        instr_reg[0]   <= instr_reg[1];
        pcplus2_reg[0] <= pcplus2_reg[1];
      end
      if (push) begin
        instr_reg[wr_idx]   <= IMem_Data;
        pcplus2_reg[wr_idx] <= tag_plus2;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a table of per-cycle vectors for streaming and freeze,
// then hand-written sequences for redirects, same-cycle drop, reset in WAIT and PC wrap.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rest = 1'b0;
  logic        freze = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jaddr = 16'h0000;
  logic        br = 1'b0;
  logic [15:0] baddr = 16'h0000;
  logic        ack_en = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] src_out;
  logic [15:0] pc2_out;
  logic        vout;

  logic        w_valid = 1'b0;
  logic [15:0] w_data = 16'h0000;
  logic        w_req;
  logic [15:0] w_addr;
  logic [15:0] w_src;
  logic [15:0] w_pc2;
  logic        w_vout;

  int pass_cnt = 0;
  int total_cnt = 0;
  int k_lat = 1;

  if_fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk(clk), .rest(rest), .Freze(freze), .Jump(jump), .JumpAddress(jaddr),
    .brTaken(br), .BranchAddress(baddr), .IMem_Req(imem_req), .IMem_Addr(imem_addr),
    .IMem_Ack(ack_en), .IMem_Valid(mem_valid), .IMem_Data(mem_data),
    .Source_Out(src_out), .PCPlus2_Out(pc2_out), .Valid_Out(vout)
  );

  // Odd reset PC exercises both bit-0 clearing and the 16-bit wrap.
  if_fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rest(rest), .Freze(1'b0), .Jump(1'b0), .JumpAddress(16'h0000),
    .brTaken(1'b0), .BranchAddress(16'h0000), .IMem_Req(w_req), .IMem_Addr(w_addr),
    .IMem_Ack(1'b1), .IMem_Valid(w_valid), .IMem_Data(w_data),
    .Source_Out(w_src), .PCPlus2_Out(w_pc2), .Valid_Out(w_vout)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Memory model: accepts at the cycle's midpoint, answers k_lat cycles later.
  logic        busy = 1'b0;
  logic [15:0] pend_addr = 16'h0000;
  int          wait_cnt = 0;
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (!rest) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        if (wait_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = mem_word(pend_addr);
          busy      = 1'b0;
          if (dut.state_reg == 2'd1 && !(br || jump) && dut.count_reg == 2'd2) begin
            total_cnt++;
            $display("FAIL push_into_full: count %0d required below 2", dut.count_reg);
          end
        end else begin
          wait_cnt--;
        end
      end
      if (imem_req && ack_en) begin
        busy      = 1'b1;
        pend_addr = imem_addr;
        wait_cnt  = k_lat - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic chk_main(input string tag, input logic req, input logic [15:0] addr,
                          input logic v, input logic [15:0] pc2);
    chk({tag, "_req"}, {15'd0, imem_req}, {15'd0, req});
    chk({tag, "_addr"}, imem_addr, addr);
    chk({tag, "_valid"}, {15'd0, vout}, {15'd0, v});
    chk({tag, "_src"}, src_out, v ? mem_word(pc2 - 16'd2) : 16'h0000);
    chk({tag, "_pc2"}, pc2_out, v ? pc2 : 16'h0000);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fz;
    logic        req;
    logic [15:0] addr;
    logic        v;
    logic [15:0] pc2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fz, input logic req, input logic [15:0] addr,
                              input logic v, input logic [15:0] pc2);
    vec_t r;
    r.fz = fz; r.req = req; r.addr = addr; r.v = v; r.pc2 = pc2;
    return r;
  endfunction

  initial begin
    // Stream from 0100 with k=1, then freeze ten cycles and release.
    vecs.push_back(mk(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0102, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 16'h0102, 1'b1, 16'h0102));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0104, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 16'h0104, 1'b1, 16'h0104));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0106, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 16'h0106, 1'b1, 16'h0106));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0108, 1'b1, 16'h0106));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, 1'b0, 16'h0108, 1'b1, 16'h0106));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0108, 1'b1, 16'h0106));
    vecs.push_back(mk(1'b0, 1'b1, 16'h0108, 1'b1, 16'h0108));
    vecs.push_back(mk(1'b0, 1'b0, 16'h010A, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 16'h010A, 1'b1, 16'h010A));

    rest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_main("reset", 1'b0, 16'h0100, 1'b0, 16'h0000);
    chk("wrap_reset_addr", w_addr, 16'hFFFE);

    next_cycle();
    rest = 1'b1;
    ack_en = 1'b1;
    foreach (vecs[i]) begin
      if (i > 0) next_cycle();
      freze = vecs[i].fz;
      @(negedge clk);
      chk_main($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v, vecs[i].pc2);
      $display("vec%0d fz=%0b req=%0b addr=%h valid=%0b src=%h pc2=%h", i, freze, imem_req,
               imem_addr, vout, src_out, pc2_out);
    end

    // Branch while waiting on a slow (k=3) response: stale word must be discarded.
    next_cycle(); k_lat = 3;
    @(negedge clk); chk_main("w0", 1'b0, 16'h010C, 1'b0, 16'h0000);
    next_cycle();
    @(negedge clk); chk_main("w1", 1'b1, 16'h010C, 1'b1, 16'h010C);
    next_cycle(); br = 1'b1; baddr = 16'h0200;
    @(negedge clk); chk_main("br_t", 1'b0, 16'h010E, 1'b0, 16'h0000);
    next_cycle(); br = 1'b0;
    @(negedge clk); chk_main("br_t1", 1'b0, 16'h0200, 1'b0, 16'h0000);
    next_cycle();
    @(negedge clk); chk_main("br_stale", 1'b0, 16'h0200, 1'b0, 16'h0000);
    next_cycle(); k_lat = 1;
    @(negedge clk); chk_main("br_req", 1'b1, 16'h0200, 1'b0, 16'h0000);
    next_cycle();
    @(negedge clk); chk_main("br_wait", 1'b0, 16'h0202, 1'b0, 16'h0000);
    $display("redirect sequence: target fetch issued, waiting for word");

    // Both redirects at once: branch target wins.
    next_cycle(); br = 1'b1; baddr = 16'h0300; jump = 1'b1; jaddr = 16'h0400;
    @(negedge clk); chk_main("br_vis", 1'b0, 16'h0202, 1'b1, 16'h0202);
    next_cycle(); br = 1'b0; jump = 1'b0;
    @(negedge clk); chk_main("prio", 1'b1, 16'h0300, 1'b0, 16'h0000);

    // Odd jump target arriving with the response: word dropped, fetch at 0300.
    next_cycle(); jump = 1'b1; jaddr = 16'h0301;
    @(negedge clk); chk_main("odd_t", 1'b0, 16'h0302, 1'b0, 16'h0000);
    next_cycle(); jump = 1'b0;
    @(negedge clk); chk_main("odd_req", 1'b1, 16'h0300, 1'b0, 16'h0000);
    next_cycle();
    @(negedge clk); chk_main("odd_wait", 1'b0, 16'h0302, 1'b0, 16'h0000);
    next_cycle(); freze = 1'b1; k_lat = 3;
    @(negedge clk); chk_main("odd_vis", 1'b1, 16'h0302, 1'b1, 16'h0302);
    $display("jump sequence: odd target aligned, head pc2=%h", pc2_out);

    // Reset while WAIT with one buffered entry.
    next_cycle();
    rest = 1'b0;
    #1;
    chk_main("rst_wait", 1'b0, 16'h0100, 1'b0, 16'h0000);
    chk("wrap_rst_addr", w_addr, 16'hFFFE);
    next_cycle();
    next_cycle(); rest = 1'b1; freze = 1'b0; k_lat = 1;
    @(negedge clk);
    chk_main("rel0", 1'b1, 16'h0100, 1'b0, 16'h0000);
    chk("wrap_req", {15'd0, w_req}, 16'h0001);
    next_cycle(); w_valid = 1'b1; w_data = 16'hBEEF;
    @(negedge clk);
    chk_main("rel1", 1'b0, 16'h0102, 1'b0, 16'h0000);
    chk("wrap_next_addr", w_addr, 16'h0000);
    next_cycle(); w_valid = 1'b0;
    @(negedge clk);
    chk_main("rel2", 1'b1, 16'h0102, 1'b1, 16'h0102);
    chk("wrap_valid", {15'd0, w_vout}, 16'h0001);
    chk("wrap_src", w_src, 16'hBEEF);
    chk("wrap_pc2", w_pc2, 16'h0000);
    $display("reset/wrap sequence: wrap pc2=%h addr=%h", w_pc2, w_addr);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
